// File: rtl/sum_sq_pkg.sv
// Shared definitions for the sum-of-squares unit and its downstream root stage.
// Holds FSM encodings, default widths and the counter-width helper.
package sum_sq_pkg;

   // Operand width of the square-root stage fed by y_bo.
   localparam int ROOT_W    = 10;
   localparam int IN_W_DEF  = 4;
   // Result width is tied to the root operand so both stay in step.
   localparam int OUT_W_DEF = ROOT_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SQ_A   = 2'd1,
      SQ_B   = 2'd2,
      FINISH = 2'd3
   } state_e;

   function automatic int ctr_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/sum_sq_step.sv
// One shift-add partial-product step: sum_o = acc_i + (op_i[idx_i] ? op_i<<idx_i : 0).
// Ports: acc_i accumulator in, op_i operand, idx_i bit index, sum_o next accumulator.
module sum_sq_step #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 10,
   parameter int CW    = 2
) (
   input  logic [OUT_W-1:0] acc_i,
   input  logic [IN_W-1:0]  op_i,
   input  logic [CW-1:0]    idx_i,
   output logic [OUT_W-1:0] sum_o
);

   logic [OUT_W-1:0] op_ext;
   logic [OUT_W-1:0] part;

   // Zero-extend before shifting so no high bits are lost.
   assign op_ext = OUT_W'(op_i);
   assign part   = op_i[idx_i] ? (op_ext << idx_i) : '0;
   assign sum_o  = acc_i + part;

endmodule

// File: rtl/sum_sq.sv
// Sequential sum-of-squares y = a*a + b*b, one partial product per clock.
// Ports: clk_i, rst_i (async high), a_bi/b_bi operands, start_i,
//        busy_o, done_o (1-cycle pulse), y_bo registered result.
module sum_sq
   import sum_sq_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int OUT_W = OUT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IN_W-1:0]  a_bi,
   input  logic [IN_W-1:0]  b_bi,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [OUT_W-1:0] y_bo
);

   localparam int CW = ctr_w(IN_W);
   localparam logic [CW-1:0] CTR_LAST = CW'(IN_W - 1);

   if (OUT_W < 2*IN_W + 1) begin : g_width_chk
      $error("sum_sq: OUT_W must be >= 2*IN_W+1");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    ctr_q,   ctr_d;
   logic [OUT_W-1:0] acc_q,   acc_d;
   logic [IN_W-1:0]  opa_q,   opa_d;
   logic [IN_W-1:0]  opb_q,   opb_d;
   logic [OUT_W-1:0] y_q,     y_d;
   logic             done_q,  done_d;

   logic [IN_W-1:0]  step_op;
   logic [OUT_W-1:0] step_sum;

   // One adder serves both squaring phases.
   assign step_op = (state_q == SQ_B) ? opb_q : opa_q;

   sum_sq_step #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .CW    (CW)
   ) u_step (
      .acc_i (acc_q),
      .op_i  (step_op),
      .idx_i (ctr_q),
      .sum_o (step_sum)
   );

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      acc_d   = acc_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      y_d     = y_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               opa_d   = a_bi;
               opb_d   = b_bi;
               acc_d   = '0;
               ctr_d   = '0;
               state_d = SQ_A;
            end
         end
         SQ_A, SQ_B: begin
            acc_d = step_sum;
            ctr_d = ctr_q + 1'b1;
            if (ctr_q == CTR_LAST) begin
               ctr_d   = '0;
               state_d = (state_q == SQ_A) ? SQ_B : FINISH;
            end
         end
         FINISH: begin
            // Only place y is written, so partial sums never show.
            y_d     = acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ctr_q   <= '0;
         acc_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         y_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         acc_q   <= acc_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         y_q     <= y_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = done_q;
   assign y_bo   = y_q;

endmodule

// File: tb/tb_sum_sq.sv
// Scoreboard bench for sum_sq: directed operand pairs with hand-computed results.
// A monitor pops expected results whenever done_o is seen.
module tb_sum_sq;

   localparam int IN_W  = 4;
   localparam int OUT_W = 10;

   logic             clk;
   logic             rst;
   logic [IN_W-1:0]  a;
   logic [IN_W-1:0]  b;
   logic             start;
   logic             busy;
   logic             done;
   logic [OUT_W-1:0] y;

   typedef struct {
      int y;
      int root;
      int edge_n;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errs   = 0;
   int   cyc    = 0;

   sum_sq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .a_bi    (a),
      .b_bi    (b),
      .start_i (start),
      .busy_o  (busy),
      .done_o  (done),
      .y_bo    (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp_v, $time);
      end
   endtask

   // Bench model of the downstream root stage.
   function automatic int isqrt(input int v);
      int r;
      r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   // Call at a negedge with the unit idle; the start is accepted at the next posedge.
   task automatic start_op(input int av, input int bv, input int yv,
                           input int rv, input bit push);
      exp_t e;
      a     = av[IN_W-1:0];
      b     = bv[IN_W-1:0];
      start = 1'b1;
      e.y      = yv;
      e.root   = rv;
      e.edge_n = cyc + 1 + 2*IN_W + 1;
      if (push) q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      // Operands are free to change once accepted.
      a = '1;
      b = '1;
   endtask

   // Returns at the negedge where done is high.
   task automatic wait_done(input string n);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) return;
      end
      errs++;
      checks++;
      $display("FAIL %s_timeout: got no done expected done within 30 cycles", n);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (q.size() == 0) begin
               errs++;
               checks++;
               $display("FAIL unexpected_done: got done=1 y=%0d expected no done", y);
            end else begin
               e = q.pop_front();
               chk("y_bo", int'(y), e.y);
               chk("done_edge", cyc, e.edge_n);
               chk("busy_in_done", int'(busy), 0);
               if (e.root >= 0) chk("root", isqrt(int'(y)), e.root);
               @(negedge clk);
               chk("done_one_cycle", int'(done), 0);
            end
         end
      end
   end

   initial begin : stim
      int bad;
      bit seen;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #1;
      chk("rst_y", int'(y), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: 3,4 with busy width
      start_op(3, 4, 25, 5, 1'b1);
      bad = 0;
      repeat (9) begin
         @(negedge clk);
         if (!busy || done) bad++;
      end
      chk("busy_9_cycles", bad, 0);
      wait_done("t1");
      @(negedge clk);

      // 2: extremes
      start_op(15, 15, 450, -1, 1'b1);
      wait_done("t2a");
      @(negedge clk);
      start_op(0, 0, 0, -1, 1'b1);
      wait_done("t2b");
      @(negedge clk);

      // 3: start while busy is ignored
      start_op(5, 2, 29, -1, 1'b1);
      repeat (3) @(negedge clk);
      a     = 4'd1;
      b     = 4'd1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done("t3");
      @(negedge clk);

      // 4: back-to-back start in the done cycle
      start_op(1, 2, 5, -1, 1'b1);
      wait_done("t4a");
      start_op(6, 8, 100, 10, 1'b1);
      wait_done("t4b");
      @(negedge clk);

      // 5: reset mid-operation
      start_op(3, 4, 25, -1, 1'b1);
      wait_done("t5a");
      @(negedge clk);
      start_op(7, 7, 98, -1, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_y", int'(y), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("no_done_after_rst", int'(seen), 0);
      chk("y_after_rst", int'(y), 0);

      // 6: chained with root stage
      start_op(6, 8, 100, 10, 1'b1);
      wait_done("t6a");
      @(negedge clk);
      start_op(15, 15, 450, 21, 1'b1);
      wait_done("t6b");
      repeat (3) @(negedge clk);

      chk("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
